// File: rtl/npc_sequencer_if.sv
// Decode/memory-side signals of the next-PC sequencer, plus state/BD debug taps.
// Slave is the sequencer itself; master is whoever drives decode/M-stage inputs.
interface npc_sequencer_if;
    logic        StallF;
    logic        StallD;
    logic        FlushE;
    logic [2:0]  BranchSelectD;
    logic        NullifyD;
    logic [31:0] BranchTargetD;
    logic [31:0] JumpTargetD;
    logic [31:0] RegTargetD;
    logic [31:0] EPCIn;
    logic        ExcReqM;
    logic [31:0] PCM;
    logic [31:0] PCF;
    logic        FlushD;
    logic        FlushM;
    logic        ExcAck;
    logic [31:0] EPCOut;
    logic        CauseBD;
    logic        EXL;
    logic        bd_d;
    logic        bd_e;
    logic        bd_m;
    logic        state_dbg;

    modport slave (
        input  StallF, StallD, FlushE, BranchSelectD, NullifyD, BranchTargetD,
               JumpTargetD, RegTargetD, EPCIn, ExcReqM, PCM,
        output PCF, FlushD, FlushM, ExcAck, EPCOut, CauseBD, EXL,
               bd_d, bd_e, bd_m, state_dbg
    );

    modport master (
        output StallF, StallD, FlushE, BranchSelectD, NullifyD, BranchTargetD,
               JumpTargetD, RegTargetD, EPCIn, ExcReqM, PCM,
        input  PCF, FlushD, FlushM, ExcAck, EPCOut, CauseBD, EXL,
               bd_d, bd_e, bd_m, state_dbg
    );
endinterface

// File: rtl/npc_sequencer.sv
// Fetch PC register and next-PC selection with delay-slot (BD) tracking
// and an exception-level state that masks nested exceptions until eret.
module npc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic               clk,
    input  logic               reset,
    npc_sequencer_if.slave     bus
);
    typedef enum logic {NORMAL = 1'b0, EXL_ST = 1'b1} state_t;

    localparam logic [2:0] SEL_SEQ = 3'd0;
    localparam logic [2:0] SEL_BR  = 3'd1;
    localparam logic [2:0] SEL_J   = 3'd2;
    localparam logic [2:0] SEL_JR  = 3'd3;
    localparam logic [2:0] SEL_RET = 3'd4;

    state_t      state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_next;
    logic [31:0] epc_q;
    logic        cause_bd_q;
    logic        bd_d_q, bd_e_q, bd_m_q;
    logic [2:0]  sel;
    logic        acc;
    logic        flush_d;
    logic        is_xfer;

    // Encodings 5..7 are unused and behave like sequential fetch.
    assign sel     = (bus.BranchSelectD > SEL_RET) ? SEL_SEQ : bus.BranchSelectD;
    assign is_xfer = (sel == SEL_BR) || (sel == SEL_J) || (sel == SEL_JR);

    always_ff @(posedge clk) begin
        if (reset) state_q <= NORMAL;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            NORMAL: if (bus.ExcReqM) state_d = EXL_ST;
            EXL_ST: if (sel == SEL_RET && !bus.StallF) state_d = NORMAL;
            default: state_d = NORMAL;
        endcase
    end

    // Outputs are forced low while reset is held so nothing leaks from stale inputs.
    always_comb begin
        acc     = 1'b0;
        flush_d = 1'b0;
        if (!reset) begin
            acc     = bus.ExcReqM && (state_q == NORMAL);
            flush_d = acc
                   || (!bus.StallF && sel == SEL_RET)
                   || (!bus.StallF && bus.NullifyD && sel == SEL_SEQ);
        end
    end

    always_comb begin
        pc_next = pc_q;
        if (acc) begin
            pc_next = HANDLER_PC;
        end else if (!bus.StallF) begin
            case (sel)
                SEL_BR:  pc_next = bus.BranchTargetD;
                SEL_J:   pc_next = bus.JumpTargetD;
                SEL_JR:  pc_next = bus.RegTargetD;
                SEL_RET: pc_next = bus.EPCIn;
                default: pc_next = pc_q + 32'd4;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            epc_q      <= 32'd0;
            cause_bd_q <= 1'b0;
            bd_d_q     <= 1'b0;
            bd_e_q     <= 1'b0;
            bd_m_q     <= 1'b0;
        end else begin
            pc_q <= pc_next;
            if (acc) begin
                // A faulting delay-slot instruction restarts at its branch.
                epc_q      <= bd_m_q ? (bus.PCM - 32'd4) : bus.PCM;
                cause_bd_q <= bd_m_q;
                bd_d_q     <= 1'b0;
                bd_e_q     <= 1'b0;
                bd_m_q     <= 1'b0;
            end else begin
                if (!bus.StallD) bd_d_q <= is_xfer && !flush_d;
                if (bus.FlushE)      bd_e_q <= 1'b0;
                else if (!bus.StallD) bd_e_q <= bd_d_q;
                bd_m_q <= bd_e_q;
            end
        end
    end

    assign bus.PCF       = pc_q;
    assign bus.FlushD    = flush_d;
    assign bus.FlushM    = acc;
    assign bus.ExcAck    = acc;
    assign bus.EPCOut    = epc_q;
    assign bus.CauseBD   = cause_bd_q;
    assign bus.EXL       = (state_q == EXL_ST);
    assign bus.bd_d      = bd_d_q;
    assign bus.bd_e      = bd_e_q;
    assign bus.bd_m      = bd_m_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_npc_sequencer.sv
// Directed bench for npc_sequencer: reset, branches under stall, delay-slot
// exceptions, nested masking, eret, likely-nullify, wrap and mid-run reset.
module tb_npc_sequencer;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    npc_sequencer_if b ();

    npc_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        b.StallF = 0; b.StallD = 0; b.FlushE = 0; b.BranchSelectD = 3'd0;
        b.NullifyD = 0; b.BranchTargetD = '0; b.JumpTargetD = '0;
        b.RegTargetD = '0; b.EPCIn = '0; b.ExcReqM = 0; b.PCM = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        b.NullifyD = 1; b.ExcReqM = 1;
        tick(); tick();
        checks++; if (b.PCF !== 32'h3000) begin failures++; $display("FAIL rst_pcf got=%h exp=%h", b.PCF, 32'h3000); end
        checks++; if (b.EXL !== 1'b0) begin failures++; $display("FAIL rst_exl got=%b exp=0", b.EXL); end
        checks++; if ({b.bd_d, b.bd_e, b.bd_m} !== 3'b000) begin failures++; $display("FAIL rst_bd got=%b exp=000", {b.bd_d, b.bd_e, b.bd_m}); end
        checks++; if (b.EPCOut !== 32'h0 || b.CauseBD !== 1'b0) begin failures++; $display("FAIL rst_cp0 got=%h/%b exp=0/0", b.EPCOut, b.CauseBD); end
        checks++; if ({b.FlushD, b.FlushM, b.ExcAck} !== 3'b000) begin failures++; $display("FAIL rst_comb got=%b exp=000", {b.FlushD, b.FlushM, b.ExcAck}); end
        reset = 0;
        idle_inputs();
        settle();
        tick();
        checks++; if (b.PCF !== 32'h3004) begin failures++; $display("FAIL seq_1 got=%h exp=%h", b.PCF, 32'h3004); end
        tick();
        checks++; if (b.PCF !== 32'h3008) begin failures++; $display("FAIL seq_2 got=%h exp=%h", b.PCF, 32'h3008); end
        tick();
        checks++; if (b.PCF !== 32'h300C) begin failures++; $display("FAIL seq_3 got=%h exp=%h", b.PCF, 32'h300C); end
        tick();
        checks++; if (b.PCF !== 32'h3010) begin failures++; $display("FAIL seq_4 got=%h exp=%h", b.PCF, 32'h3010); end
    endtask

    task automatic test_branch_stall();
        b.StallF = 1; b.BranchSelectD = 3'd1; b.BranchTargetD = 32'h3040;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (b.PCF !== 32'h3010) begin failures++; $display("FAIL stall_hold%0d got=%h exp=%h", i, b.PCF, 32'h3010); end
        end
        b.StallF = 0;
        settle();
        checks++; if (b.FlushD !== 1'b0) begin failures++; $display("FAIL br_flushd got=%b exp=0", b.FlushD); end
        tick();
        checks++; if (b.PCF !== 32'h3040) begin failures++; $display("FAIL br_target got=%h exp=%h", b.PCF, 32'h3040); end
        checks++; if (b.bd_d !== 1'b1) begin failures++; $display("FAIL br_bd_d got=%b exp=1", b.bd_d); end
        b.BranchSelectD = 3'd0;
        tick();
        checks++; if (b.bd_e !== 1'b1 || b.bd_d !== 1'b0) begin failures++; $display("FAIL br_bd_e got=%b/%b exp=1/0", b.bd_e, b.bd_d); end
        tick();
        checks++; if (b.bd_m !== 1'b1) begin failures++; $display("FAIL br_bd_m got=%b exp=1", b.bd_m); end
        checks++; if (b.PCF !== 32'h3048) begin failures++; $display("FAIL br_seq got=%h exp=%h", b.PCF, 32'h3048); end
    endtask

    task automatic test_exc_delay_slot();
        b.PCM = 32'h3044; b.ExcReqM = 1; b.StallF = 1;
        b.BranchSelectD = 3'd2; b.JumpTargetD = 32'h5000;
        settle();
        checks++; if ({b.ExcAck, b.FlushD, b.FlushM} !== 3'b111) begin failures++; $display("FAIL exc_comb got=%b exp=111", {b.ExcAck, b.FlushD, b.FlushM}); end
        tick();
        b.ExcReqM = 0; b.StallF = 0; b.BranchSelectD = 3'd0;
        checks++; if (b.PCF !== 32'h4180) begin failures++; $display("FAIL exc_pcf got=%h exp=%h", b.PCF, 32'h4180); end
        checks++; if (b.EPCOut !== 32'h3040) begin failures++; $display("FAIL exc_epc got=%h exp=%h", b.EPCOut, 32'h3040); end
        checks++; if (b.CauseBD !== 1'b1) begin failures++; $display("FAIL exc_causebd got=%b exp=1", b.CauseBD); end
        checks++; if (b.EXL !== 1'b1) begin failures++; $display("FAIL exc_exl got=%b exp=1", b.EXL); end
        checks++; if ({b.bd_d, b.bd_e, b.bd_m} !== 3'b000) begin failures++; $display("FAIL exc_bdclr got=%b exp=000", {b.bd_d, b.bd_e, b.bd_m}); end
    endtask

    task automatic test_nested_eret();
        b.ExcReqM = 1; b.PCM = 32'h4180;
        settle();
        checks++; if ({b.ExcAck, b.FlushM, b.FlushD} !== 3'b000) begin failures++; $display("FAIL nest_comb got=%b exp=000", {b.ExcAck, b.FlushM, b.FlushD}); end
        tick();
        checks++; if (b.PCF !== 32'h4184 || b.EXL !== 1'b1) begin failures++; $display("FAIL nest_pc got=%h/%b exp=%h/1", b.PCF, b.EXL, 32'h4184); end
        checks++; if (b.EPCOut !== 32'h3040) begin failures++; $display("FAIL nest_epc got=%h exp=%h", b.EPCOut, 32'h3040); end
        b.BranchSelectD = 3'd4; b.EPCIn = 32'h3040;
        settle();
        checks++; if (b.FlushD !== 1'b1 || b.ExcAck !== 1'b0) begin failures++; $display("FAIL eret_comb got=%b/%b exp=1/0", b.FlushD, b.ExcAck); end
        tick();
        b.ExcReqM = 0; b.BranchSelectD = 3'd0;
        checks++; if (b.PCF !== 32'h3040 || b.EXL !== 1'b0) begin failures++; $display("FAIL eret_ret got=%h/%b exp=%h/0", b.PCF, b.EXL, 32'h3040); end
        checks++; if (b.bd_d !== 1'b0) begin failures++; $display("FAIL eret_bd got=%b exp=0", b.bd_d); end
    endtask

    task automatic test_likely();
        b.BranchSelectD = 3'd2; b.JumpTargetD = 32'h3020;
        tick();
        checks++; if (b.PCF !== 32'h3020 || b.bd_d !== 1'b1) begin failures++; $display("FAIL j_target got=%h/%b exp=%h/1", b.PCF, b.bd_d, 32'h3020); end
        b.BranchSelectD = 3'd0; b.NullifyD = 1;
        settle();
        checks++; if (b.FlushD !== 1'b1) begin failures++; $display("FAIL null_flushd got=%b exp=1", b.FlushD); end
        tick();
        checks++; if (b.PCF !== 32'h3024 || b.bd_d !== 1'b0) begin failures++; $display("FAIL null_pc got=%h/%b exp=%h/0", b.PCF, b.bd_d, 32'h3024); end
        b.BranchSelectD = 3'd3; b.RegTargetD = 32'h3100;
        settle();
        checks++; if (b.FlushD !== 1'b0) begin failures++; $display("FAIL null_sel_wins got=%b exp=0", b.FlushD); end
        tick();
        b.NullifyD = 0; b.BranchSelectD = 3'd0;
        checks++; if (b.PCF !== 32'h3100 || b.bd_d !== 1'b1) begin failures++; $display("FAIL jr_target got=%h/%b exp=%h/1", b.PCF, b.bd_d, 32'h3100); end
        tick(); tick(); tick();
        checks++; if (b.PCF !== 32'h310C || b.bd_m !== 1'b0) begin failures++; $display("FAIL drain got=%h/%b exp=%h/0", b.PCF, b.bd_m, 32'h310C); end
    endtask

    task automatic test_exc_vs_eret();
        b.BranchSelectD = 3'd4; b.EPCIn = 32'h7777_0000; b.ExcReqM = 1; b.PCM = 32'h3100;
        settle();
        checks++; if (b.ExcAck !== 1'b1 || b.FlushD !== 1'b1) begin failures++; $display("FAIL xe_comb got=%b/%b exp=1/1", b.ExcAck, b.FlushD); end
        tick();
        b.ExcReqM = 0; b.BranchSelectD = 3'd0;
        checks++; if (b.PCF !== 32'h4180 || b.EXL !== 1'b1) begin failures++; $display("FAIL xe_pc got=%h/%b exp=%h/1", b.PCF, b.EXL, 32'h4180); end
        checks++; if (b.EPCOut !== 32'h3100 || b.CauseBD !== 1'b0) begin failures++; $display("FAIL xe_epc got=%h/%b exp=%h/0", b.EPCOut, b.CauseBD, 32'h3100); end
    endtask

    task automatic test_wrap();
        b.BranchSelectD = 3'd4; b.StallF = 1; b.EPCIn = 32'hFFFF_FFFC;
        settle();
        checks++; if (b.FlushD !== 1'b0) begin failures++; $display("FAIL eret_stall_fd got=%b exp=0", b.FlushD); end
        tick();
        checks++; if (b.PCF !== 32'h4180 || b.EXL !== 1'b1) begin failures++; $display("FAIL eret_stall got=%h/%b exp=%h/1", b.PCF, b.EXL, 32'h4180); end
        b.StallF = 0;
        tick();
        b.BranchSelectD = 3'd0;
        checks++; if (b.PCF !== 32'hFFFF_FFFC || b.EXL !== 1'b0) begin failures++; $display("FAIL wrap_pre got=%h/%b exp=fffffffc/0", b.PCF, b.EXL); end
        tick();
        checks++; if (b.PCF !== 32'h0) begin failures++; $display("FAIL wrap got=%h exp=0", b.PCF); end
        b.BranchSelectD = 3'd5; b.BranchTargetD = 32'h9000;
        tick();
        b.BranchSelectD = 3'd0;
        checks++; if (b.PCF !== 32'h4 || b.bd_d !== 1'b0) begin failures++; $display("FAIL sel5_seq got=%h/%b exp=4/0", b.PCF, b.bd_d); end
    endtask

    task automatic test_flush_e();
        b.BranchSelectD = 3'd1; b.BranchTargetD = 32'h0100;
        tick();
        b.BranchSelectD = 3'd0; b.FlushE = 1;
        tick();
        b.FlushE = 0;
        checks++; if (b.bd_e !== 1'b0) begin failures++; $display("FAIL flushe_bd got=%b exp=0", b.bd_e); end
        b.BranchSelectD = 3'd1; b.BranchTargetD = 32'h0200;
        tick();
        b.BranchSelectD = 3'd0; b.StallD = 1;
        tick(); tick();
        checks++; if (b.bd_e !== 1'b0 || b.bd_d !== 1'b1) begin failures++; $display("FAIL stalld_hold got=%b/%b exp=0/1", b.bd_e, b.bd_d); end
        b.StallD = 0;
        tick();
        checks++; if (b.bd_e !== 1'b1 || b.bd_d !== 1'b0) begin failures++; $display("FAIL stalld_rel got=%b/%b exp=1/0", b.bd_e, b.bd_d); end
    endtask

    task automatic test_reset_mid();
        b.ExcReqM = 1; b.PCM = 32'h0208;
        tick();
        checks++; if (b.EXL !== 1'b1 || b.CauseBD !== 1'b0) begin failures++; $display("FAIL mid_exl got=%b/%b exp=1/0", b.EXL, b.CauseBD); end
        b.StallF = 1; reset = 1;
        settle();
        checks++; if (b.ExcAck !== 1'b0 || b.FlushD !== 1'b0) begin failures++; $display("FAIL mid_comb got=%b/%b exp=0/0", b.ExcAck, b.FlushD); end
        tick();
        checks++; if (b.PCF !== 32'h3000 || b.EXL !== 1'b0) begin failures++; $display("FAIL mid_rst got=%h/%b exp=%h/0", b.PCF, b.EXL, 32'h3000); end
        checks++; if (b.EPCOut !== 32'h0 || {b.bd_d, b.bd_e, b.bd_m} !== 3'b000) begin failures++; $display("FAIL mid_rst_st got=%h/%b exp=0/000", b.EPCOut, {b.bd_d, b.bd_e, b.bd_m}); end
        reset = 0;
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1;
        idle_inputs();
        test_reset();
        test_branch_stall();
        test_exc_delay_slot();
        test_nested_eret();
        test_likely();
        test_exc_vs_eret();
        test_wrap();
        test_flush_e();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/npc_sequencer.md
Name: npc_sequencer

Overview:
Owns the fetch PC register and decides the next PC every cycle. Candidates are PC+4, the resolved branch, jump or register targets from decode, the eret return, and the exception handler. It tracks the branch-delay-slot (BD) flag alongside each instruction through D/E/M so that a faulting instruction reports the correct EPC and Cause.BD. It also holds the exception-level state that masks nested exceptions until eret.

Parameters:
RESET_PC, 32'h0000_3000, PCF value after reset
HANDLER_PC, 32'h0000_4180, exception vector loaded on an accepted exception

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
StallF  in  1  hold PCF
StallD  in  1  hold D-stage BD flag
FlushE  in  1  bubble into E (clears E BD flag)
BranchSelectD  in  3  0=seq, 1=branch, 2=j/jal, 3=jr/jalr, 4=eret, 5..7 treated as 0
NullifyD  in  1  likely-branch not taken; kill delay slot
BranchTargetD  in  32  PC-relative target
JumpTargetD  in  32  j/jal target
RegTargetD  in  32  jr/jalr register value
EPCIn  in  32  saved EPC for eret
ExcReqM  in  1  M-stage instruction raises exception/interrupt
PCM  in  32  PC of M-stage instruction
PCF  out  32  fetch PC
FlushD  out  1  discard instruction entering D
FlushM  out  1  kill younger pipeline stages on exception
ExcAck  out  1  exception accepted this cycle
EPCOut  out  32  registered EPC for CP0
CauseBD  out  1  registered BD bit for CP0
EXL  out  1  exception level, 1 = handler running

Behaviour:
- Reset (synchronous) values: PCF=RESET_PC; BD flags D/E/M=0; EPCOut=0; CauseBD=0; state=NORMAL (EXL=0). Combinational outputs go to 0 while reset is high.
- FSM has two states:
  - NORMAL -> EXL when ExcReqM=1.
  - EXL -> NORMAL when BranchSelectD=4 and StallF=0.
  - In EXL, ExcReqM is ignored: ExcAck=0, FlushM=0, no redirect.
- Accepted exception (acc = ExcReqM & state==NORMAL): overrides StallF and every decode redirect.
  - Next cycle: PCF=HANDLER_PC; EPCOut = BD_M ? PCM-4 : PCM; CauseBD = BD_M; BD_D/E/M cleared.
  - Same cycle: ExcAck=1, FlushM=1, FlushD=1.
- No accepted exception and StallF=1: PCF holds. BranchSelectD is not latched, because decode re-presents it after the stall.
- No accepted exception and StallF=0: PCF <= PCF+4 / BranchTargetD / JumpTargetD / RegTargetD / EPCIn for BranchSelectD 0/1/2/3/4 respectively. Addition is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- FlushD (combinational):
  - acc, or
  - ~StallF & BranchSelectD==4 (eret has no delay slot), or
  - ~StallF & NullifyD (likely not taken).
  - When NullifyD=1 and BranchSelectD!=0 both hold, BranchSelectD wins and FlushD=0.
- BD tracking, evaluated when no exception is accepted:
  - D: if ~StallD, BD_D <= (BranchSelectD in {1,2,3}) & ~FlushD.
  - E: BD_E <= FlushE ? 0 : (StallD ? BD_E : BD_D).
  - M: BD_M <= BD_E.
  - An eret or nullified slot never sets BD.
- Latency: redirect takes effect 1 cycle after the decision. EPCOut/CauseBD are valid 1 cycle after ExcAck.
- Precedence: reset > accepted exception > StallF > BranchSelectD.
- Same-cycle conflicts:
  - eret in D with an accepted exception: exception wins, state stays EXL after the transition.
  - ExcReqM and eret both present while in EXL: the eret is taken and state returns to NORMAL; ExcReqM is ignored that cycle.
- Reset mid-operation: asserting reset during EXL or during a stall restores the reset values on the next edge, regardless of other inputs.

Test Plan:
- Reset: hold reset 2 cycles, then run 3 cycles with StallF=0, BranchSelectD=0 -> PCF = 3000, 3004, 3008, 300C.
- Taken beq: PCF=3010, BranchSelectD=1, BranchTargetD=3040 -> next PCF=3040; BD_D=1; two cycles later BD_M=1.
- Branch under stall: StallF=1 with BranchSelectD=1 for 3 cycles -> PCF holds at 3010; cycle 4 with StallF=0 -> PCF=3040.
- Exception in delay slot: BD_M=1, PCM=3044, ExcReqM=1, StallF=1 -> ExcAck=1, FlushD=1, FlushM=1. Next cycle: PCF=4180, EPCOut=3040, CauseBD=1, EXL=1.
- Nested masking and eret: in EXL, pulse ExcReqM -> no ExcAck and PCF advances by 4. Then BranchSelectD=4, EPCIn=3040 -> FlushD=1; next cycle PCF=3040, EXL=0.
- Likely not taken: NullifyD=1, BranchSelectD=0, PCF=3020 -> FlushD=1; next PCF=3024; BD_D=0.
